// File: rtl/sram_arb_ctrl_if.sv
// Bundle of both requester ports and the SRAM command/data port around sram_arb_ctrl.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface sram_arb_ctrl_if;
    logic        iReqA;
    logic        iWrA;
    logic [3:0]  iAddrA;
    logic [31:0] iWrDtA;
    logic        oGntA;
    logic        oRdVldA;
    logic [31:0] oRdDtA;

    logic        iReqB;
    logic        iWrB;
    logic [3:0]  iAddrB;
    logic [31:0] iWrDtB;
    logic        oGntB;
    logic        oRdVldB;
    logic [31:0] oRdDtB;

    logic        oCsn;
    logic        oWrn;
    logic [3:0]  oAddr;
    logic [31:0] oWrDt;
    logic [31:0] iRdDt;

    modport slave (
        input  iReqA, iWrA, iAddrA, iWrDtA,
        input  iReqB, iWrB, iAddrB, iWrDtB,
        input  iRdDt,
        output oGntA, oRdVldA, oRdDtA,
        output oGntB, oRdVldB, oRdDtB,
        output oCsn, oWrn, oAddr, oWrDt
    );

    modport master (
        output iReqA, iWrA, iAddrA, iWrDtA,
        output iReqB, iWrB, iAddrB, iWrDtB,
        output iRdDt,
        input  oGntA, oRdVldA, oRdDtA,
        input  oGntB, oRdVldB, oRdDtB,
        input  oCsn, oWrn, oAddr, oWrDt
    );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-requester arbiter/sequencer for a 16x32 single-port SRAM with 1-cycle registered read.
// Grants are one-cycle pulses aligned with the SRAM command; read data is routed back by tag.
module sram_arb_ctrl #(
    parameter int unsigned P_BURST     = 1,
    parameter bit          P_FIXED_PRI = 1'b0
) (
    input logic           iClk,
    input logic           iRst,
    sram_arb_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(P_BURST + 1);

    typedef enum logic {OwnA, OwnB} owner_e;

    owner_e          owner_q, owner_d;
    logic [CntW-1:0] burst_q, burst_d;

    logic        win_vld;
    logic        win_b;
    logic        sel_wr;
    logic [3:0]  sel_addr;
    logic [31:0] sel_wrdt;

    logic        gnt_a_q, gnt_b_q;
    logic        csn_q, wrn_q;
    logic [3:0]  addr_q;
    logic [31:0] wrdt_q;
    logic        tag1_vld_q, tag1_b_q;
    logic        tag2_vld_q, tag2_b_q;
    logic        rd_vld_a_q, rd_vld_b_q;
    logic [31:0] rd_dt_a_q, rd_dt_b_q;

    // Burst limit only matters on contention; a lone requester always wins.
    always_comb begin
        win_vld = bus.iReqA | bus.iReqB;
        win_b   = bus.iReqB;
        if (bus.iReqA && bus.iReqB) begin
            if (P_FIXED_PRI) begin
                win_b = 1'b0;
            end else if (burst_q < CntW'(P_BURST)) begin
                win_b = (owner_q == OwnB);
            end else begin
                win_b = (owner_q == OwnA);
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (win_vld) begin
            if ((owner_q == OwnB) == win_b) begin
                if (burst_q < CntW'(P_BURST)) begin
                    burst_d = burst_q + CntW'(1);
                end
            end else begin
                owner_d = win_b ? OwnB : OwnA;
                burst_d = CntW'(1);
            end
        end
    end

    assign sel_wr   = win_b ? bus.iWrB   : bus.iWrA;
    assign sel_addr = win_b ? bus.iAddrB : bus.iAddrA;
    assign sel_wrdt = win_b ? bus.iWrDtB : bus.iWrDtA;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            owner_q    <= OwnA;
            burst_q    <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            csn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            addr_q     <= '0;
            wrdt_q     <= '0;
            tag1_vld_q <= 1'b0;
            tag1_b_q   <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_b_q   <= 1'b0;
            rd_vld_a_q <= 1'b0;
            rd_vld_b_q <= 1'b0;
            rd_dt_a_q  <= '0;
            rd_dt_b_q  <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            gnt_a_q <= win_vld & ~win_b;
            gnt_b_q <= win_vld & win_b;
            csn_q   <= ~win_vld;
            // Command fields hold while idle so the SRAM pins stay quiet.
            if (win_vld) begin
                wrn_q  <= ~sel_wr;
                addr_q <= sel_addr;
                wrdt_q <= sel_wrdt;
            end
            // Stage 1 = command cycle, stage 2 = SRAM data cycle.
            tag1_vld_q <= win_vld & ~sel_wr;
            tag1_b_q   <= win_b;
            tag2_vld_q <= tag1_vld_q;
            tag2_b_q   <= tag1_b_q;
            rd_vld_a_q <= tag2_vld_q & ~tag2_b_q;
            rd_vld_b_q <= tag2_vld_q & tag2_b_q;
            if (tag2_vld_q && !tag2_b_q) begin
                rd_dt_a_q <= bus.iRdDt;
            end
            if (tag2_vld_q && tag2_b_q) begin
                rd_dt_b_q <= bus.iRdDt;
            end
        end
    end

    assign bus.oGntA   = gnt_a_q;
    assign bus.oGntB   = gnt_b_q;
    assign bus.oCsn    = csn_q;
    assign bus.oWrn    = wrn_q;
    assign bus.oAddr   = addr_q;
    assign bus.oWrDt   = wrdt_q;
    assign bus.oRdVldA = rd_vld_a_q;
    assign bus.oRdVldB = rd_vld_b_q;
    assign bus.oRdDtA  = rd_dt_a_q;
    assign bus.oRdDtB  = rd_dt_b_q;

    a_gnt_onehot: assert property (@(posedge iClk) disable iff (iRst)
        !(gnt_a_q && gnt_b_q));
    a_gnt_csn: assert property (@(posedge iClk) disable iff (iRst)
        (gnt_a_q || gnt_b_q) == !csn_q);
    a_vld_onehot: assert property (@(posedge iClk) disable iff (iRst)
        !(rd_vld_a_q && rd_vld_b_q));

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench: three arbiters (RR burst 1, RR burst 3, fixed priority), each with a behavioural SRAM,
// driven by per-requester stimulus and compared every cycle against a transaction-level model.
module tb_sram_arb_ctrl;

    typedef enum int {MIdle, MRand, MRr, MBurst, MBoth, MWrRd, MRdOnce} mode_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // stimulus
    logic [2:0]  req_a, wr_a, req_b, wr_b;
    logic [3:0]  addr_a [3];
    logic [3:0]  addr_b [3];
    logic [31:0] wd_a [3];
    logic [31:0] wd_b [3];

    // observed
    logic [2:0]  gnt_a, gnt_b, vld_a, vld_b, csn, wrn;
    logic [3:0]  addr [3];
    logic [31:0] wrdt [3];
    logic [31:0] rddt_a [3];
    logic [31:0] rddt_b [3];

    // expected
    logic [2:0]  e_gnt_a, e_gnt_b, e_vld_a, e_vld_b, e_csn, e_wrn;
    logic [3:0]  e_addr [3];
    logic [31:0] e_wrdt [3];
    logic [31:0] e_rd_a [3];
    logic [31:0] e_rd_b [3];

    // model state
    int          burst_cfg [3] = '{1, 3, 1};
    bit          fix_cfg [3]   = '{1'b0, 1'b0, 1'b1};
    int          owner [3];
    int          streak [3];
    bit          pw_v [3];
    logic [3:0]  pw_a [3];
    logic [31:0] pw_d [3];
    logic [31:0] mem_m [3][16];
    bit          sv [3][4];
    bit          sw [3][4];
    logic [31:0] sd [3][4];

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    phase_cyc = 0;
    mode_e mode = MIdle;
    int    cnt_a [3];
    int    cnt_b [3];
    logic [3:0] rr_hist;
    logic [4:0] bu_hist;
    int    fp_bcnt;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sram_arb_ctrl_if bus ();
        logic [31:0] mem [16];
        logic [31:0] rd_q;

        assign bus.iReqA  = req_a[k];
        assign bus.iWrA   = wr_a[k];
        assign bus.iAddrA = addr_a[k];
        assign bus.iWrDtA = wd_a[k];
        assign bus.iReqB  = req_b[k];
        assign bus.iWrB   = wr_b[k];
        assign bus.iAddrB = addr_b[k];
        assign bus.iWrDtB = wd_b[k];
        assign bus.iRdDt  = rd_q;

        assign gnt_a[k]  = bus.oGntA;
        assign gnt_b[k]  = bus.oGntB;
        assign vld_a[k]  = bus.oRdVldA;
        assign vld_b[k]  = bus.oRdVldB;
        assign rddt_a[k] = bus.oRdDtA;
        assign rddt_b[k] = bus.oRdDtB;
        assign csn[k]    = bus.oCsn;
        assign wrn[k]    = bus.oWrn;
        assign addr[k]   = bus.oAddr;
        assign wrdt[k]   = bus.oWrDt;

        initial begin
            rd_q <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end

        always @(posedge clk) begin
            if (!bus.oCsn) begin
                if (!bus.oWrn) mem[bus.oAddr] <= bus.oWrDt;
                else           rd_q <= mem[bus.oAddr];
            end
        end

        sram_arb_ctrl #(
            .P_BURST    ((k == 1) ? 3 : 1),
            .P_FIXED_PRI(k == 2)
        ) u_dut (
            .iClk(clk),
            .iRst(rst),
            .bus (bus)
        );
    end

    task automatic check(input string tag, input int k, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", tag, k, $time, got, exp);
        end
    endtask

    task automatic check_inst(input int k);
        check("gntA", k, 32'(gnt_a[k]), 32'(e_gnt_a[k]));
        check("gntB", k, 32'(gnt_b[k]), 32'(e_gnt_b[k]));
        check("csn", k, 32'(csn[k]), 32'(e_csn[k]));
        check("wrn", k, 32'(wrn[k]), 32'(e_wrn[k]));
        check("addr", k, 32'(addr[k]), 32'(e_addr[k]));
        check("wrdt", k, wrdt[k], e_wrdt[k]);
        check("vldA", k, 32'(vld_a[k]), 32'(e_vld_a[k]));
        check("vldB", k, 32'(vld_b[k]), 32'(e_vld_b[k]));
        check("rdA", k, rddt_a[k], e_rd_a[k]);
        check("rdB", k, rddt_b[k], e_rd_b[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            owner[k] = 0; streak[k] = 0; pw_v[k] = 1'b0;
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            e_gnt_a[k] = 1'b0; e_gnt_b[k] = 1'b0; e_vld_a[k] = 1'b0; e_vld_b[k] = 1'b0;
            e_csn[k] = 1'b1; e_wrn[k] = 1'b1; e_addr[k] = '0; e_wrdt[k] = '0;
            e_rd_a[k] = '0; e_rd_b[k] = '0;
            req_a[k] = 1'b0; req_b[k] = 1'b0; wr_a[k] = 1'b0; wr_b[k] = 1'b0;
            addr_a[k] = '0; addr_b[k] = '0; wd_a[k] = '0; wd_b[k] = '0;
        end
    endtask

    // Outcome of the coming edge from the requests now presented.
    task automatic predict(input int k);
        int win, n, slot;
        bit w;
        logic [3:0]  a;
        logic [31:0] d;
        n = cyc % 4;
        if (pw_v[k]) begin
            mem_m[k][pw_a[k]] = pw_d[k];
            pw_v[k] = 1'b0;
        end
        win = -1;
        if (req_a[k] && req_b[k]) begin
            if (fix_cfg[k])                    win = 0;
            else if (streak[k] < burst_cfg[k]) win = owner[k];
            else                               win = 1 - owner[k];
        end else if (req_a[k]) win = 0;
        else if (req_b[k])     win = 1;
        e_gnt_a[k] = (win == 0);
        e_gnt_b[k] = (win == 1);
        e_csn[k]   = (win < 0);
        if (win >= 0) begin
            w = (win == 1) ? wr_b[k] : wr_a[k];
            a = (win == 1) ? addr_b[k] : addr_a[k];
            d = (win == 1) ? wd_b[k] : wd_a[k];
            e_wrn[k] = !w; e_addr[k] = a; e_wrdt[k] = d;
            if (win == owner[k]) streak[k]++;
            else begin owner[k] = win; streak[k] = 1; end
            if (w) begin
                pw_v[k] = 1'b1; pw_a[k] = a; pw_d[k] = d;
            end else begin
                slot = (cyc + 2) % 4;
                sv[k][slot] = 1'b1; sw[k][slot] = (win == 1); sd[k][slot] = mem_m[k][a];
            end
        end
        e_vld_a[k] = sv[k][n] && !sw[k][n];
        e_vld_b[k] = sv[k][n] && sw[k][n];
        if (e_vld_a[k]) e_rd_a[k] = sd[k][n];
        if (e_vld_b[k]) e_rd_b[k] = sd[k][n];
        sv[k][n] = 1'b0;
    endtask

    task automatic new_req(input int k, input int who);
        bit r, w;
        logic [3:0]  a;
        logic [31:0] d;
        int n;
        n = (who == 0) ? cnt_a[k] : cnt_b[k];
        r = 1'b0; w = 1'b0; a = 4'(who); d = $urandom;
        case (mode)
            MRand:   begin
                r = ($urandom_range(0, 9) < 7);
                w = 1'($urandom_range(0, 1));
                a = 4'($urandom_range(0, 15));
            end
            MRr:     begin r = 1'b1; a = (who == 0) ? 4'd1 : 4'd2; end
            MBurst:  begin
                r = (who == 0) || (phase_cyc >= 2 && n < 1);
                a = 4'(4 + who);
            end
            MBoth:   begin r = 1'b1; a = 4'($urandom_range(0, 15)); end
            MWrRd:   if (who == 0 && n < 2) begin
                r = 1'b1; w = (n == 0); a = 4'd3; d = 32'hDEADBEEF;
            end
            MRdOnce: if (who == 0 && n < 1) begin r = 1'b1; a = 4'd3; end
            default: ;
        endcase
        if (who == 0) begin
            req_a[k] = r; wr_a[k] = w; addr_a[k] = a; wd_a[k] = d;
            if (r) cnt_a[k]++;
        end else begin
            req_b[k] = r; wr_b[k] = w; addr_b[k] = a; wd_b[k] = d;
            if (r) cnt_b[k]++;
        end
    endtask

    task automatic step();
        for (int k = 0; k < 3; k++) predict(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) check_inst(k);
    endtask

    // Requests are held until granted; a grant frees the requester to issue again.
    task automatic upd_reqs();
        for (int k = 0; k < 3; k++) begin
            if (!req_a[k] || e_gnt_a[k]) new_req(k, 0);
            if (!req_b[k] || e_gnt_b[k]) new_req(k, 1);
        end
    endtask

    task automatic run_phase(input mode_e m, input int n);
        mode = m;
        phase_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            cnt_a[k] = 0; cnt_b[k] = 0;
            if (!req_a[k]) new_req(k, 0);
            if (!req_b[k]) new_req(k, 1);
        end
        for (int i = 0; i < n; i++) begin
            step();
            phase_cyc++;
            if (m == MRr && i < 4)    rr_hist = {rr_hist[2:0], gnt_a[0]};
            if (m == MBurst && i < 5) bu_hist = {bu_hist[3:0], gnt_b[1]};
            if (m == MBoth)           fp_bcnt += int'(gnt_b[2]);
            upd_reqs();
        end
    endtask

    // Asserted mid-cycle; outputs must be at reset values before the next edge.
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) check_inst(k);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
        rr_hist = '0;
        bu_hist = '0;
        fp_bcnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        run_phase(MIdle, 2);
        run_phase(MWrRd, 8);
        for (int k = 0; k < 3; k++) check("wr_then_rd", k, rddt_a[k], 32'hDEADBEEF);

        reset_pulse();
        run_phase(MRr, 8);
        check("rr_grant_seq", 0, 32'(rr_hist), 32'hA);
        run_phase(MIdle, 4);

        reset_pulse();
        run_phase(MBurst, 8);
        check("burst_grant_seq", 1, 32'(bu_hist), 32'h2);
        run_phase(MIdle, 4);

        run_phase(MBoth, 10);
        check("fixpri_b_starved", 2, 32'(fp_bcnt), 32'd0);
        run_phase(MIdle, 4);

        run_phase(MRdOnce, 2);
        reset_pulse();
        run_phase(MIdle, 4);
        run_phase(MRdOnce, 5);
        for (int k = 0; k < 3; k++) check("rd_after_rst", k, rddt_a[k], 32'hDEADBEEF);

        repeat (4) begin
            run_phase(MRand, 120);
            reset_pulse();
        end
        run_phase(MIdle, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Two-requester arbiter and sequencer for the 16x32 single-port SRAM (1-cycle registered read, active-low chip select, write on oWrn=0).
- Serialises requesters A and B onto the SRAM command port.
- Generates chip select and write enable for the SRAM and returns read data to the owning requester with a valid strobe.
- Sits between the bridge-side masters and the SRAM instance.

Parameters:
- P_BURST, 1, max consecutive grants to one requester while the other is requesting (1..8).
- P_FIXED_PRI, 0, 0 = round-robin with burst limit; 1 = A always wins, P_BURST ignored.

Ports:
- iClk  input  1  rising-edge clock
- iRst  input  1  asynchronous, active-high reset
- iReqA  input  1  requester A access request
- iWrA  input  1  A: 1 = write, 0 = read
- iAddrA  input  4  A word address
- iWrDtA  input  32  A write data
- oGntA  output  1  one-cycle grant pulse to A
- oRdVldA  output  1  A read data valid (one cycle)
- oRdDtA  output  32  A read data
- iReqB, iWrB, iAddrB, iWrDtB, oGntB, oRdVldB, oRdDtB  same widths and meaning for requester B
- oCsn  output  1  SRAM chip select, active low
- oWrn  output  1  SRAM 0 = write, 1 = read
- oAddr  output  4  SRAM address
- oWrDt  output  32  SRAM write data
- iRdDt  input  32  SRAM read data (valid the cycle after a read command)

Behaviour:
- Reset (async assert, sync release on iClk):
  - oCsn=1, oWrn=1, oAddr=0, oWrDt=0.
  - oGntA/B=0, oRdVldA/B=0, oRdDtA/B=0.
  - Round-robin pointer = A (next tie goes to A), burst counter = 0, read tags cleared.
- Arbitration at every rising edge samples iReq*:
  - Neither requesting: oCsn=1 next cycle; oWrn, oAddr, oWrDt hold their values.
  - One requesting: that one wins.
  - Both requesting, P_FIXED_PRI=1: A wins.
  - Both requesting, P_FIXED_PRI=0: the current owner wins while burst counter < P_BURST; otherwise the other wins.
- Burst counter:
  - Counts consecutive grants to the same requester.
  - Resets to 1 on owner change.
  - Saturates at P_BURST.
  - Only limits the owner when the other requester is asserting.
- Grant cycle (cycle after sampling):
  - oGnt of winner = 1.
  - oCsn=0; oWrn=~iWr; oAddr and oWrDt are registered copies of the winner's fields sampled at the arbitration edge.
  - Exactly one of oGntA/oGntB is high; oGnt* always coincides with oCsn=0.
- Request handshake:
  - Requester holds iReq and its fields stable until it sees oGnt.
  - If iReq is still high at the edge ending the grant cycle, it is a new request. This gives back-to-back throughput of 1 access/cycle.
- Read latency:
  - Request sampled at edge E0; command on SRAM during cycle 1; SRAM data on iRdDt in cycle 2.
  - Data registered into oRdDt* with oRdVld*=1 during cycle 3.
  - Total 3 cycles from sampling edge to valid.
- Read tagging:
  - A 2-stage tag pipeline (valid, owner) routes each result to the correct requester.
  - Pipelined reads from alternating requesters each return in order, one per cycle.
  - oRdDt* of the non-selected requester holds its last value.
- Writes: no response strobe; write completes at the edge ending the grant cycle.
- Read after write to the same address, issued in consecutive grants: read returns the new data; the SRAM is updated before the read command edge, so no hazard logic is needed.
- Reset mid-operation: in-flight reads are discarded (no oRdVld* after reset release); any pending grant is dropped; outputs go to reset values immediately.

Test Plan:
- Reset: assert iRst asynchronously mid-cycle -> oCsn=1, all oGnt*/oRdVld*=0 before the next edge.
- Single write then read:
  - A writes addr 3 = 0xDEADBEEF -> oGntA, oCsn=0, oWrn=0.
  - A reads addr 3 -> oRdVldA=1 with oRdDtA=0xDEADBEEF exactly 3 cycles after the sampling edge; oRdVldB stays 0.
- Round-robin, P_BURST=1: A and B both hold reads of addr 1 and 2 for 4 grants -> grants alternate A,B,A,B; oRdVld alternates A,B with the correct data each cycle.
- Burst limit, P_BURST=3: A requests continuously, B requests from cycle 2 -> A gets 3 consecutive grants, then B is granted, then A again.
- Fixed priority, P_FIXED_PRI=1: both request continuously -> A granted every cycle, B never granted until iReqA drops, then B granted the next cycle.
- Reset during read: A read issued, iRst pulsed in the cycle data is on iRdDt -> no oRdVldA after release; the next read returns correct data.
